// File: rtl/mor1kx_wb_arbiter_cappuccino.sv
// Writeback arbiter: grants one of ALU/LSU/MUL per cycle onto the single RF write
// port and registers the selected write. ALU is boosted after repeated denials.
module mor1kx_wb_arbiter_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int STARVE_LIMIT         = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_valid_i,
  output logic                            alu_ready_o,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] alu_addr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] alu_result_i,
  input  logic                            lsu_valid_i,
  output logic                            lsu_ready_o,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_i,
  input  logic                            mul_valid_i,
  output logic                            mul_ready_o,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] mul_addr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] mul_result_i,
  input  logic                            flush_i,
  output logic                            rf_we_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] rf_addr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_result_o,
  output logic [1:0]                      wb_src_o,
  output logic                            stall_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ALU  = 2'd1;
  localparam logic [1:0] SRC_LSU  = 2'd2;
  localparam logic [1:0] SRC_MUL  = 2'd3;

  logic [3:0]                      starve_cnt;
  logic                            boost;
  logic                            any_grant;
  logic [1:0]                      sel_src;
  logic [OPTION_RF_ADDR_WIDTH-1:0] sel_addr;
  logic [OPTION_OPERAND_WIDTH-1:0] sel_result;

  assign boost = alu_valid_i && (starve_cnt == LIMIT);

  // Readies are forced low during reset so no handshake can complete while held.
  always_comb begin
    alu_ready_o = 1'b0;
    lsu_ready_o = 1'b0;
    mul_ready_o = 1'b0;
    if (rst && !flush_i) begin
      if (boost)            alu_ready_o = 1'b1;
      else if (lsu_valid_i) lsu_ready_o = 1'b1;
      else if (mul_valid_i) mul_ready_o = 1'b1;
      else if (alu_valid_i) alu_ready_o = 1'b1;
    end
  end

  assign any_grant = alu_ready_o | lsu_ready_o | mul_ready_o;
  assign stall_o   = (alu_valid_i & ~alu_ready_o) |
                     (lsu_valid_i & ~lsu_ready_o) |
                     (mul_valid_i & ~mul_ready_o);

  always_comb begin
    sel_src    = SRC_NONE;
    sel_addr   = alu_addr_i;
    sel_result = alu_result_i;
    if (lsu_ready_o) begin
      sel_src    = SRC_LSU;
      sel_addr   = lsu_addr_i;
      sel_result = lsu_result_i;
    end else if (mul_ready_o) begin
      sel_src    = SRC_MUL;
      sel_addr   = mul_addr_i;
      sel_result = mul_result_i;
    end else if (alu_ready_o) begin
      sel_src    = SRC_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!alu_valid_i || alu_ready_o || flush_i) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Address/data hold on idle cycles; only enable and source are cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_o     <= 1'b0;
      rf_addr_o   <= '0;
      rf_result_o <= '0;
      wb_src_o    <= SRC_NONE;
    end else if (any_grant) begin
      rf_we_o     <= (sel_addr != '0);
      rf_addr_o   <= sel_addr;
      rf_result_o <= sel_result;
      wb_src_o    <= sel_src;
    end else begin
      rf_we_o     <= 1'b0;
      wb_src_o    <= SRC_NONE;
    end
  end

endmodule

// File: tb/tb_mor1kx_wb_arbiter_cappuccino.sv
// Directed bench for the writeback arbiter: priority, starvation boost, flush,
// r0 suppression and asynchronous reset.
module tb_mor1kx_wb_arbiter_cappuccino;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, mul_valid, flush;
  logic        alu_ready, lsu_ready, mul_ready;
  logic [4:0]  alu_addr, lsu_addr, mul_addr, rf_addr;
  logic [31:0] alu_result, lsu_result, mul_result, rf_result;
  logic        rf_we, stall;
  logic [1:0]  wb_src;

  int n_pass = 0;
  int n_total = 0;

  mor1kx_wb_arbiter_cappuccino dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid_i  (alu_valid),
    .alu_ready_o  (alu_ready),
    .alu_addr_i   (alu_addr),
    .alu_result_i (alu_result),
    .lsu_valid_i  (lsu_valid),
    .lsu_ready_o  (lsu_ready),
    .lsu_addr_i   (lsu_addr),
    .lsu_result_i (lsu_result),
    .mul_valid_i  (mul_valid),
    .mul_ready_o  (mul_ready),
    .mul_addr_i   (mul_addr),
    .mul_result_i (mul_result),
    .flush_i      (flush),
    .rf_we_o      (rf_we),
    .rf_addr_o    (rf_addr),
    .rf_result_o  (rf_result),
    .wb_src_o     (wb_src),
    .stall_o      (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a,
                        input logic [31:0] d, input logic [1:0] s);
    chk({tag, ".we"},   32'(rf_we),  32'(we));
    chk({tag, ".addr"}, 32'(rf_addr), 32'(a));
    chk({tag, ".data"}, rf_result,    d);
    chk({tag, ".src"},  32'(wb_src), 32'(s));
  endtask

  // ALU held to dst with LSU streaming new loads: four denials, then boosted grant.
  task automatic starve_round(input logic [4:0] dst, input logic [31:0] val, input int base);
    alu_valid = 1'b1; alu_addr = dst; alu_result = val;
    lsu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lsu_addr = 5'(base + i); lsu_result = 32'(100 + base + i);
      #1;
      chk("starve.alu_deny", 32'(alu_ready), 32'd0);
      chk("starve.lsu_gnt",  32'(lsu_ready), 32'd1);
      tick();
      chk_wr("starve.lsu_wr", 1'b1, 5'(base + i), 32'(100 + base + i), 2'd2);
    end
    lsu_addr = 5'(base + 4); lsu_result = 32'(100 + base + 4);
    #1;
    chk("boost.alu_gnt",  32'(alu_ready), 32'd1);
    chk("boost.lsu_deny", 32'(lsu_ready), 32'd0);
    chk("boost.stall",    32'(stall),     32'd1);
    tick();
    chk_wr("boost.wr", 1'b1, dst, val, 2'd1);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    alu_valid = 1'b1; lsu_valid = 1'b0; mul_valid = 1'b0;
    alu_addr = 5'd1; lsu_addr = 5'd0; mul_addr = 5'd0;
    alu_result = '0; lsu_result = '0; mul_result = '0;
    tick(); tick();
    chk_wr("reset", 1'b0, 5'd0, 32'd0, 2'd0);
    chk("reset.alu_ready", 32'(alu_ready), 32'd0);
    alu_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    tick();

    // ALU only
    alu_valid = 1'b1; alu_addr = 5'd3; alu_result = 32'h1234;
    #1;
    chk("alu.ready", 32'(alu_ready), 32'd1);
    chk("alu.stall", 32'(stall),     32'd0);
    tick(); alu_valid = 1'b0;
    chk_wr("alu.wr", 1'b1, 5'd3, 32'h1234, 2'd1);

    // All three: LSU, then MUL, then ALU
    lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_result = 32'hA;
    mul_valid = 1'b1; mul_addr = 5'd5; mul_result = 32'hB;
    alu_valid = 1'b1; alu_addr = 5'd6; alu_result = 32'hC;
    #1;
    chk("all.lsu_ready", 32'(lsu_ready), 32'd1);
    chk("all.stall0",    32'(stall),     32'd1);
    tick(); lsu_valid = 1'b0; #1;
    chk_wr("all.wr_lsu", 1'b1, 5'd4, 32'hA, 2'd2);
    chk("all.mul_ready", 32'(mul_ready), 32'd1);
    chk("all.stall1",    32'(stall),     32'd1);
    tick(); mul_valid = 1'b0; #1;
    chk_wr("all.wr_mul", 1'b1, 5'd5, 32'hB, 2'd3);
    chk("all.alu_ready", 32'(alu_ready), 32'd1);
    chk("all.stall2",    32'(stall),     32'd0);
    tick(); alu_valid = 1'b0;
    chk_wr("all.wr_alu", 1'b1, 5'd6, 32'hC, 2'd1);
    tick();
    chk_wr("idle.hold", 1'b0, 5'd6, 32'hC, 2'd0);

    // Starvation twice in a row: second round shows the counter cleared on grant
    starve_round(5'd7, 32'h77, 8);
    starve_round(5'd9, 32'h99, 16);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();

    // Flush
    mul_valid = 1'b1; mul_addr = 5'd10; mul_result = 32'hB0;
    alu_valid = 1'b1; alu_addr = 5'd11; alu_result = 32'hA1;
    flush = 1'b1;
    #1;
    chk("flush.mul_ready", 32'(mul_ready), 32'd0);
    chk("flush.alu_ready", 32'(alu_ready), 32'd0);
    tick(); flush = 1'b0; #1;
    chk("flush.we",  32'(rf_we),  32'd0);
    chk("flush.src", 32'(wb_src), 32'd0);
    chk("flush.mul_after", 32'(mul_ready), 32'd1);
    tick(); mul_valid = 1'b0; #1;
    chk_wr("flush.wr_mul", 1'b1, 5'd10, 32'hB0, 2'd3);
    chk("flush.alu_after", 32'(alu_ready), 32'd1);
    tick(); alu_valid = 1'b0;
    chk_wr("flush.wr_alu", 1'b1, 5'd11, 32'hA1, 2'd1);

    // r0 write
    lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_result = 32'hFFFF;
    #1;
    chk("r0.lsu_ready", 32'(lsu_ready), 32'd1);
    tick(); lsu_valid = 1'b0;
    chk_wr("r0.wr", 1'b0, 5'd0, 32'hFFFF, 2'd2);

    // Async reset mid-burst
    lsu_valid = 1'b1; lsu_addr = 5'd12; lsu_result = 32'hC12;
    mul_valid = 1'b1; mul_addr = 5'd13; mul_result = 32'hD13;
    tick(); lsu_valid = 1'b0;
    chk("arst.pre_we", 32'(rf_we), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_wr("arst.now", 1'b0, 5'd0, 32'd0, 2'd0);
    chk("arst.mul_ready", 32'(mul_ready), 32'd0);
    alu_valid = 1'b1; alu_addr = 5'd14; alu_result = 32'hE14;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("arst.post_mul", 32'(mul_ready), 32'd1);
    chk("arst.post_alu", 32'(alu_ready), 32'd0);
    tick(); mul_valid = 1'b0;
    chk_wr("arst.post_wr", 1'b1, 5'd13, 32'hD13, 2'd3);
    tick(); alu_valid = 1'b0;
    chk_wr("arst.post_alu_wr", 1'b1, 5'd14, 32'hE14, 2'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mor1kx_wb_arbiter_cappuccino.md
Name: mor1kx_wb_arbiter_cappuccino

Overview:
Arbitrates the single register-file write port between three result producers: ALU/SPR (execute), LSU (load data), and multiplier. Each producer offers a result through a valid/ready handshake. The block grants at most one producer per cycle and registers the selected write, so the RF sees one cycle of latency. It sits between the execute-stage result sources and the RF write port, replacing fixed-timing writeback selection where producers complete out of step.

Parameters:
OPTION_OPERAND_WIDTH, 32, width of result data.
OPTION_RF_ADDR_WIDTH, 5, width of RF destination address.
STARVE_LIMIT, 4, consecutive denied ALU cycles before ALU is boosted to top priority (range 1..15).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-low reset.
alu_valid_i  in  1  ALU/SPR result offered.
alu_ready_o  out  1  ALU result accepted this cycle.
alu_addr_i  in  OPTION_RF_ADDR_WIDTH  ALU destination register.
alu_result_i  in  OPTION_OPERAND_WIDTH  ALU/SPR result.
lsu_valid_i  in  1  load result offered.
lsu_ready_o  out  1  load result accepted.
lsu_addr_i  in  OPTION_RF_ADDR_WIDTH  load destination register.
lsu_result_i  in  OPTION_OPERAND_WIDTH  load data.
mul_valid_i  in  1  multiply result offered.
mul_ready_o  out  1  multiply result accepted.
mul_addr_i  in  OPTION_RF_ADDR_WIDTH  multiply destination register.
mul_result_i  in  OPTION_OPERAND_WIDTH  multiply result.
flush_i  in  1  pipeline flush; blocks all grants this cycle.
rf_we_o  out  1  registered RF write enable.
rf_addr_o  out  OPTION_RF_ADDR_WIDTH  registered RF write address.
rf_result_o  out  OPTION_OPERAND_WIDTH  registered RF write data.
wb_src_o  out  2  registered source of the current write: 0 none, 1 ALU, 2 LSU, 3 MUL.
stall_o  out  1  combinational; high when any valid requester is not granted this cycle.

Behaviour:
- Reset (rst low, async): rf_we_o=0, rf_addr_o=0, rf_result_o=0, wb_src_o=0, starvation counter=0. All ready outputs are 0 while rst is low.
- Handshake: a transfer occurs when valid and ready are both high on a rising edge. Ready is combinational from valids, counter, and flush_i. Producers hold valid, addr, and data stable until accepted. The block never asserts ready without valid.
- Grant: at most one ready per cycle. Normal priority is LSU > MUL > ALU. If the starvation counter equals STARVE_LIMIT and alu_valid_i=1, priority becomes ALU > LSU > MUL.
- Starvation counter, 4 bits, saturating at STARVE_LIMIT:
  - increments when alu_valid_i=1 and alu_ready_o=0 and flush_i=0;
  - clears on an ALU grant, on flush_i=1, or when alu_valid_i=0.
- Flush: with flush_i=1, all ready outputs are 0 and no new write is registered in that cycle (rf_we_o=0 and wb_src_o=0 next cycle). A write already registered from the previous cycle still appears on the outputs.
- Output register, next cycle after a grant:
  - rf_addr_o and rf_result_o take the granted producer's address and data;
  - wb_src_o takes the granted source code;
  - rf_we_o=1 unless the address is 0.
  With no grant: rf_we_o=0, wb_src_o=0, and rf_addr_o/rf_result_o hold their previous values.
- Register r0: a grant to address 0 completes the handshake and sets wb_src_o, but rf_we_o stays 0.
- Same destination from several producers in one cycle: only the winner is written. Losers retry and are written in later cycles in grant order, so the last write wins.
- Throughput: one write per cycle sustained. Latency from grant to RF write is exactly 1 cycle.
- Reset mid-transfer: any pending grant is discarded and outputs return to their reset values immediately. No write survives reset deassertion.

Test Plan:
- After reset, ALU only: alu_valid_i=1, alu_addr_i=3, alu_result_i=0x1234 for one cycle → alu_ready_o=1 in the same cycle; next cycle rf_we_o=1, rf_addr_o=3, rf_result_o=0x1234, wb_src_o=1.
- All three valid (LSU→r4=0xA, MUL→r5=0xB, ALU→r6=0xC), held until accepted → writes over three consecutive cycles: r4 (src 2), r5 (src 3), r6 (src 1); stall_o=1 for the first two cycles.
- Starvation: LSU valid continuously with a new load every cycle, ALU valid to r7 → ALU denied for 4 cycles, then granted on the 5th with LSU ready=0 that cycle; counter returns to 0.
- Flush: MUL and ALU valid with flush_i=1 for one cycle → both ready=0; next cycle rf_we_o=0, wb_src_o=0; on the following cycle MUL is granted.
- r0 write: lsu_valid_i=1, lsu_addr_i=0, data 0xFFFF → lsu_ready_o=1; next cycle rf_we_o=0, wb_src_o=2.
- Async reset asserted mid-burst, between clock edges → rf_we_o and wb_src_o drop to 0 without waiting for a clock edge, and all ready outputs go to 0. After release, the first grant follows normal priority.
